// File: rtl/aq_rtu_cmplt_arb_pkg.sv
// Shared definitions for the EX1 completion-slot arbiter.
// No logic; constants only.
// Carries requester numbering, source encoding and parameter defaults.
package aq_rtu_cmplt_arb_pkg;

    localparam int NUM_REQ_DEF  = 4;
    localparam int WAIT_W_DEF   = 3;
    localparam int MAX_WAIT_DEF = 6;

    // Long-latency requester slots, in fixed-priority order for starvation.
    typedef enum logic [1:0] {
        REQ_DIV = 2'd0,
        REQ_LSU = 2'd1,
        REQ_VEC = 2'd2,
        REQ_CP0 = 2'd3
    } req_id_e;

    // Completion source: MSB set means the single-cycle units own the slot.
    localparam int              SRC_W_DEF = $clog2(NUM_REQ_DEF) + 1;
    localparam logic [SRC_W_DEF-1:0] SRC_FAST = {1'b1, {(SRC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/aq_rtu_rr_pick.sv
// Rotating-priority picker: first set bit of req searching upward from ptr.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the pick is used.
//
// Ports:
//   req  - request vector
//   ptr  - index of highest-priority position this cycle
//   gnt  - one-hot grant (all zero when no request)
//   idx  - binary index of the granted position
//   any  - at least one request present
module aq_rtu_rr_pick #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = 0; k < N; k++) begin
            // Wrap explicitly so non-power-of-two N still works.
            pos = IW'((int'(ptr) + k) % N);
            if (!any && req[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/aq_rtu_cmplt_arb.sv
// Arbiter for the single EX1 completion slot: fast units first, then starving
// long-latency requesters (lowest index), then round-robin among the rest.
// Latency: grant is combinational; stall to IDU is registered (one cycle).
// Backpressure: slow requesters hold req until acked; fast completions cannot
// be held, so starvation is relieved by stalling issue to the fast units.
//
// Ports:
//   forever_cpuclk - clock
//   cpurst         - synchronous active-high reset
//   fast_cmplt     - single-cycle unit completion this cycle
//   slow_req       - long-latency completion requests (0 DIV,1 LSU,2 VEC,3 CP0)
//   flush          - commit clear; kills slow grants and clears wait state
//   slow_ack       - one-hot grant to a long-latency requester
//   arb_ex1_cmplt  - slot used this cycle
//   arb_cmplt_src  - MSB=1 fast, else index of acked requester
//   arb_idu_stall  - registered stall of new single-cycle issue
//   arb_busy       - request pending or stall active
module aq_rtu_cmplt_arb
    import aq_rtu_cmplt_arb_pkg::*;
#(
    parameter  int NUM_REQ  = NUM_REQ_DEF,
    parameter  int WAIT_W   = WAIT_W_DEF,
    parameter  int MAX_WAIT = MAX_WAIT_DEF,
    localparam int IDX_W    = $clog2(NUM_REQ),
    localparam int SRC_W    = IDX_W + 1
) (
    input  logic               forever_cpuclk,
    input  logic               cpurst,
    input  logic               fast_cmplt,
    input  logic [NUM_REQ-1:0] slow_req,
    input  logic               flush,
    output logic [NUM_REQ-1:0] slow_ack,
    output logic               arb_ex1_cmplt,
    output logic [SRC_W-1:0]   arb_cmplt_src,
    output logic               arb_idu_stall,
    output logic               arb_busy
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]  rr_ptr;
    logic [WAIT_W-1:0] wait_cnt [NUM_REQ];
    logic [WAIT_W-1:0] wait_nxt [NUM_REQ];
    logic              stall_q;
    logic              stall_nxt;

    logic [NUM_REQ-1:0] starve_vec;
    logic [NUM_REQ-1:0] starve_gnt;
    logic [IDX_W-1:0]   starve_idx;
    logic               starve_any;
    logic [NUM_REQ-1:0] rr_gnt;
    logic [IDX_W-1:0]   rr_idx;
    logic               rr_any;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;

    // A saturated counter only matters while its request is still held.
    always_comb begin
        starve_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            starve_vec[i] = slow_req[i] && (wait_cnt[i] == WAIT_MAX);
        end
    end

    // Starvation pick is fixed priority: same picker, pointer pinned at 0.
    aq_rtu_rr_pick #(.N(NUM_REQ)) u_starve_pick (
        .req (starve_vec),
        .ptr ('0),
        .gnt (starve_gnt),
        .idx (starve_idx),
        .any (starve_any)
    );

    aq_rtu_rr_pick #(.N(NUM_REQ)) u_rr_pick (
        .req (slow_req),
        .ptr (rr_ptr),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (rr_any)
    );

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        if (!cpurst && !fast_cmplt && !flush) begin
            if (starve_any) begin
                grant     = starve_gnt;
                grant_idx = starve_idx;
            end else if (rr_any) begin
                grant     = rr_gnt;
                grant_idx = rr_idx;
            end
        end
    end

    assign grant_any = |grant;

    // Fast completion passes even under flush; retire qualifies it with commit.
    always_comb begin
        slow_ack      = grant;
        arb_ex1_cmplt = !cpurst && (fast_cmplt || grant_any);
        arb_cmplt_src = '0;
        if (!cpurst) begin
            if (fast_cmplt) begin
                arb_cmplt_src = {1'b1, {IDX_W{1'b0}}};
            end else if (grant_any) begin
                arb_cmplt_src = {1'b0, grant_idx};
            end
        end
        arb_idu_stall = !cpurst && stall_q;
        arb_busy      = !cpurst && ((|slow_req) || stall_q);
    end

    // Stall is derived from next-cycle counters so it rises together with the
    // counter reaching the limit and drops right after that requester retires.
    always_comb begin
        stall_nxt = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            wait_nxt[i] = '0;
            if (!flush && slow_req[i] && !grant[i]) begin
                wait_nxt[i] = (wait_cnt[i] == WAIT_MAX) ? WAIT_MAX
                                                        : wait_cnt[i] + 1'b1;
            end
            if (wait_nxt[i] == WAIT_MAX) begin
                stall_nxt = 1'b1;
            end
        end
        if (flush) begin
            stall_nxt = 1'b0;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            rr_ptr  <= '0;
            stall_q <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            if (grant_any) begin
                rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            end
            stall_q <= stall_nxt;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= wait_nxt[i];
            end
        end
    end

endmodule
